// File: rtl/offset_writeback.sv
// rtl/offset_writeback.sv - post-increment writeback and software write merge for the offset memory
module offset_writeback #(
  parameter int WORD_WIDTH   = 12,
  parameter int ADDR_WIDTH   = 3,
  parameter int INCR_WIDTH   = 4,
  parameter int READ_LATENCY = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  read_valid,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  input  logic                  incr_enable,
  input  logic [INCR_WIDTH-1:0] increment,
  input  logic [WORD_WIDTH-1:0] offset,
  input  logic                  sw_wren,
  input  logic [ADDR_WIDTH-1:0] sw_addr,
  input  logic [WORD_WIDTH-1:0] sw_data,
  output logic                  wren,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [WORD_WIDTH-1:0] write_data,
  output logic                  incr_dropped
);

  logic [READ_LATENCY-1:0]                 tag_valid;
  logic [READ_LATENCY-1:0][ADDR_WIDTH-1:0] tag_addr;
  logic [READ_LATENCY-1:0][INCR_WIDTH-1:0] tag_incr;

  logic                  hold_valid;
  logic [ADDR_WIDTH-1:0] hold_addr;
  logic [WORD_WIDTH-1:0] hold_data;

  logic                  cand_valid;
  logic [ADDR_WIDTH-1:0] cand_addr;
  logic [WORD_WIDTH-1:0] cand_data;
  logic [WORD_WIDTH-1:0] incr_ext;

  logic                  next_wren;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [WORD_WIDTH-1:0] next_data;
  logic                  next_drop;
  logic                  next_hold_valid;
  logic [ADDR_WIDTH-1:0] next_hold_addr;
  logic [WORD_WIDTH-1:0] next_hold_data;
  logic                  hold_hit;
  logic                  cand_hit;

  // Tags travel alongside the memory read so the last stage lines up with offset.
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_valid <= '0;
    end else begin
      tag_valid[0] <= read_valid & incr_enable;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
      end
    end
    tag_addr[0] <= read_addr;
    tag_incr[0] <= increment;
    for (int i = 1; i < READ_LATENCY; i++) begin
      tag_addr[i] <= tag_addr[i-1];
      tag_incr[i] <= tag_incr[i-1];
    end
  end

  assign incr_ext   = {{(WORD_WIDTH-INCR_WIDTH){tag_incr[READ_LATENCY-1][INCR_WIDTH-1]}},
                       tag_incr[READ_LATENCY-1]};
  assign cand_valid = tag_valid[READ_LATENCY-1];
  assign cand_addr  = tag_addr[READ_LATENCY-1];
  assign cand_data  = offset + incr_ext;

  assign hold_hit = hold_valid && (hold_addr == sw_addr);
  assign cand_hit = cand_valid && (cand_addr == sw_addr);

  always_comb begin
    next_wren       = 1'b0;
    next_addr       = write_addr;
    next_data       = write_data;
    next_drop       = 1'b0;
    next_hold_valid = hold_valid;
    next_hold_addr  = hold_addr;
    next_hold_data  = hold_data;
    if (sw_wren) begin
      next_wren = 1'b1;
      next_addr = sw_addr;
      next_data = sw_data;
      if (hold_hit) begin
        next_hold_valid = 1'b0;
        next_drop       = 1'b1;
      end
      // A held entry discarded by the software write frees the buffer for this candidate.
      if (cand_hit) begin
        next_drop = 1'b1;
      end else if (cand_valid) begin
        if (!hold_valid || hold_hit) begin
          next_hold_valid = 1'b1;
          next_hold_addr  = cand_addr;
          next_hold_data  = cand_data;
        end else begin
          next_drop = 1'b1;
        end
      end
    end else if (hold_valid) begin
      next_wren       = 1'b1;
      next_addr       = hold_addr;
      next_data       = hold_data;
      next_hold_valid = cand_valid;
      next_hold_addr  = cand_addr;
      next_hold_data  = cand_data;
    end else if (cand_valid) begin
      next_wren = 1'b1;
      next_addr = cand_addr;
      next_data = cand_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wren         <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
      incr_dropped <= 1'b0;
      hold_valid   <= 1'b0;
      hold_addr    <= '0;
      hold_data    <= '0;
    end else begin
      wren         <= next_wren;
      write_addr   <= next_addr;
      write_data   <= next_data;
      incr_dropped <= next_drop;
      hold_valid   <= next_hold_valid;
      hold_addr    <= next_hold_addr;
      hold_data    <= next_hold_data;
    end
  end

endmodule

// File: tb/tb_offset_writeback.sv
// tb/tb_offset_writeback.sv - scoreboard bench for offset_writeback
module tb_offset_writeback;
  localparam int W = 12;
  localparam int A = 3;
  localparam int I = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         read_valid = 1'b0;
  logic [A-1:0] read_addr = '0;
  logic         incr_enable = 1'b0;
  logic [I-1:0] increment = '0;
  logic [W-1:0] offset = '0;
  logic         sw_wren = 1'b0;
  logic [A-1:0] sw_addr = '0;
  logic [W-1:0] sw_data = '0;
  logic         wren;
  logic [A-1:0] write_addr;
  logic [W-1:0] write_data;
  logic         incr_dropped;

  offset_writeback dut (
    .clock(clock), .reset(reset), .read_valid(read_valid), .read_addr(read_addr),
    .incr_enable(incr_enable), .increment(increment), .offset(offset),
    .sw_wren(sw_wren), .sw_addr(sw_addr), .sw_data(sw_data), .wren(wren),
    .write_addr(write_addr), .write_data(write_data), .incr_dropped(incr_dropped)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic [A-1:0] addr;
    logic [W-1:0] data;
  } wr_t;

  typedef struct {
    logic [A-1:0] addr;
    logic [I-1:0] inc;
    logic         en;
    logic [W-1:0] off;
    logic [W-1:0] exp;
  } vec_t;

  wr_t          exp_q[$];
  int           drop_q[$];
  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] hist[3] = '{default: '0};
  logic [W-1:0] rd_off = '0;
  vec_t         tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: offset returns three cycles after the read is issued.
  task automatic tick();
    offset = hist[2];
    @(posedge clock);
    #1;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = rd_off;
    read_valid = 0; read_addr = 0; incr_enable = 0; increment = 0; rd_off = 0;
    sw_wren = 0; sw_addr = 0; sw_data = 0;
  endtask

  task automatic issue(input logic [A-1:0] a, input logic [I-1:0] inc, input logic en,
                       input logic [W-1:0] off, input logic push, input logic [W-1:0] exp);
    read_valid = 1; read_addr = a; incr_enable = en; increment = inc; rd_off = off;
    if (push && en) exp_q.push_back('{cyc + 4, a, exp});
  endtask

  task automatic sw(input logic [A-1:0] a, input logic [W-1:0] d);
    sw_wren = 1; sw_addr = a; sw_data = d;
    exp_q.push_back('{cyc + 1, a, d});
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL missing_write: got no write, expected addr %0h data %0h at cycle %0d",
               exp_q[0].addr, exp_q[0].data, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (wren !== 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h at cycle %0d, expected no write",
                 write_addr, write_data, cyc);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (e.cyc != cyc || write_addr !== e.addr || write_data !== e.data || wren !== 1'b1) begin
          errors++;
          $display("FAIL write: got addr %0h data %0h at cycle %0d, expected addr %0h data %0h at cycle %0d",
                   write_addr, write_data, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
    if (drop_q.size() > 0 && drop_q[0] < cyc) begin
      checks++; errors++;
      $display("FAIL missing_drop: got no pulse, expected pulse at cycle %0d", drop_q[0]);
      void'(drop_q.pop_front());
    end
    if (incr_dropped !== 1'b0) begin
      checks++;
      if (drop_q.size() == 0 || drop_q[0] != cyc) begin
        errors++;
        $display("FAIL incr_dropped: got %b at cycle %0d, expected 0", incr_dropped, cyc);
      end else begin
        void'(drop_q.pop_front());
      end
    end
  end

  initial begin
    int k;
    tbl[0] = '{3'd2, 4'h1, 1'b1, 12'h010, 12'h011};
    tbl[1] = '{3'd0, 4'hF, 1'b1, 12'h000, 12'hFFF};
    tbl[2] = '{3'd1, 4'h7, 1'b1, 12'hFFC, 12'h003};
    tbl[3] = '{3'd3, 4'h1, 1'b1, 12'hFFF, 12'h000};
    tbl[4] = '{3'd4, 4'h8, 1'b1, 12'h005, 12'hFFD};
    tbl[5] = '{3'd5, 4'h0, 1'b1, 12'h7A3, 12'h7A3};
    tbl[6] = '{3'd6, 4'h3, 1'b0, 12'h123, 12'h000};
    tbl[7] = '{3'd7, 4'h3, 1'b1, 12'h0FE, 12'h101};

    reset = 1;
    repeat (2) tick();
    chk("reset_wren", wren, 0);
    chk("reset_write_addr", write_addr, 0);
    chk("reset_write_data", write_data, 0);
    chk("reset_incr_dropped", incr_dropped, 0);
    reset = 0;
    tick();

    for (int i = 0; i < 8; i++) begin
      issue(tbl[i].addr, tbl[i].inc, tbl[i].en, tbl[i].off, 1'b1, tbl[i].exp);
      tick();
    end
    repeat (6) tick();

    sw(3'd5, 12'h123);
    tick();
    repeat (4) tick();

    // Candidate collides with a software write to a different address.
    k = cyc;
    issue(3'd1, 4'h2, 1'b1, 12'h040, 1'b0, '0);
    repeat (3) tick();
    sw(3'd4, 12'h0AA);
    exp_q.push_back('{k + 5, 3'd1, 12'h042});
    tick();
    repeat (5) tick();

    // Same-address collision: software value wins.
    k = cyc;
    issue(3'd3, 4'h1, 1'b1, 12'h100, 1'b0, '0);
    repeat (3) tick();
    sw(3'd3, 12'h555);
    drop_q.push_back(k + 4);
    tick();
    repeat (5) tick();

    // Hold buffer full: second colliding candidate is dropped.
    k = cyc;
    issue(3'd1, 4'h1, 1'b1, 12'h010, 1'b0, '0);
    tick();
    issue(3'd2, 4'h1, 1'b1, 12'h020, 1'b0, '0);
    tick();
    tick();
    sw(3'd4, 12'h111);
    tick();
    sw(3'd6, 12'h222);
    drop_q.push_back(k + 5);
    exp_q.push_back('{k + 6, 3'd1, 12'h011});
    tick();
    repeat (5) tick();

    // Reset while three increment reads are in flight.
    for (int i = 0; i < 3; i++) begin
      issue(3'(i), 4'h1, 1'b1, 12'h300, 1'b0, '0);
      tick();
    end
    reset = 1;
    tick();
    reset = 0;
    chk("post_reset_wren", wren, 0);
    chk("post_reset_write_addr", write_addr, 0);
    chk("post_reset_write_data", write_data, 0);
    chk("post_reset_incr_dropped", incr_dropped, 0);
    repeat (5) tick();
    issue(3'd2, 4'h1, 1'b1, 12'h2F0, 1'b1, 12'h2F1);
    tick();
    repeat (6) tick();

    chk("pending_writes", exp_q.size(), 0);
    chk("pending_drops", drop_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion before 100000");
    $fatal(1);
  end
endmodule

// File: doc/offset_writeback.md
Name: offset_writeback

Overview:
- Write-side companion to the per-thread programmed offset memory.
- Tracks each offset read issued to the memory and captures the offset value when it returns.
- When post-increment is requested, computes offset + increment and writes the result back into the offset memory.
- Merges software (I/O-mapped) offset writes onto the single memory write port; software writes always take priority.

Parameters:
WORD_WIDTH, 12, width of one offset word
ADDR_WIDTH, 3, offset memory address width
INCR_WIDTH, 4, width of signed post-increment value
READ_LATENCY, 3, cycles from read_addr issue to offset valid (1 RAM + 2 pipeline)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
read_valid  in  1  an offset read is being issued this cycle
read_addr  in  ADDR_WIDTH  address of the issued read
incr_enable  in  1  post-increment the offset for this read
increment  in  INCR_WIDTH  signed two's-complement increment for this read
offset  in  WORD_WIDTH  offset value from memory, valid READ_LATENCY cycles after issue
sw_wren  in  1  software write request
sw_addr  in  ADDR_WIDTH  software write address
sw_data  in  WORD_WIDTH  software write data
wren  out  1  memory write enable
write_addr  out  ADDR_WIDTH  memory write address
write_data  out  WORD_WIDTH  memory write data
incr_dropped  out  1  one-cycle pulse: a post-increment write was discarded

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- Tag pipeline:
  - READ_LATENCY stages carry {valid = read_valid & incr_enable, addr, increment}.
  - The tag at the last stage is aligned with offset.
- Sum: offset + sign-extended increment, modulo 2^WORD_WIDTH. Wraps silently in both directions (0xFFF + 1 = 0x000; 0x000 + (-1) = 0xFFF).
- Candidate write: the sum plus its address is registered one cycle after offset is valid. Increment-write latency from issue to wren is therefore READ_LATENCY+1 = 4 cycles.
- Hold buffer: one entry {hold_valid, hold_addr, hold_data}.
- Write-port arbitration, evaluated each cycle in this priority order:
  1. sw_wren=1: write sw_addr/sw_data.
     - A candidate to a different address goes into the hold buffer if it is empty.
     - If the buffer is full, the candidate is dropped and incr_dropped pulses.
     - A candidate or held entry whose address equals sw_addr is discarded (software value wins) and incr_dropped pulses. This applies to both if both match; the pulse is still one cycle.
  2. Else if hold_valid: write the held entry and clear the buffer. A new candidate arriving in the same cycle moves into the buffer.
  3. Else if a candidate is present: write the candidate.
  4. Else: wren=0.
- Outputs are registered. Software write latency is sw_wren to wren = 1 cycle.
- Non-increment reads (incr_enable=0) flow through the tag pipeline with valid=0 and never produce a write.
- No read-after-write forwarding. Memory depth (one slot per thread) guarantees the same address is not re-read within READ_LATENCY+2 cycles.
- Reset: clears all tag valids, hold_valid, wren, incr_dropped, write_addr and write_data to 0. Reads in flight during reset are lost; the first write after reset can only come from a read or sw write issued at or after the reset-release cycle.
- write_addr and write_data are don't-care when wren=0, but held at their last value (0 after reset).

Test Plan:
1. Basic post-increment: issue read addr 2, incr +1, offset returns 0x010 at t+3 → wren=1, write_addr=2, write_data=0x011 at t+4.
2. Negative and wrap:
   - incr -1 (0xF) on offset 0x000 → write_data=0xFFF.
   - incr +7 on 0xFFC → 0x003.
3. Software write, no collision: sw_wren addr 5 data 0x123 with no reads → wren one cycle later, addr 5, data 0x123; incr_dropped=0.
4. Collision, different address: candidate for addr 1 in the same cycle as sw write to addr 4 → sw write emitted first, then addr 1 incremented value on the next cycle from the hold buffer.
5. Collision, same address and overflow:
   - sw write to addr 3 coincident with candidate for addr 3 → only the sw value is written; incr_dropped pulses once.
   - With the hold buffer full, a second coincident collision drops the new candidate; incr_dropped=1.
6. Reset mid-flight: issue incremented reads on 3 consecutive cycles, assert reset for 1 cycle → no wren for any of them; all outputs 0 the cycle after reset; a new read after release writes back normally.
